// File: rtl/udp_tx_packetizer_if.sv
// Sample-stream input and MAC byte-transmit output of the UDP packetizer.
// master = packetizer side, slave = upstream source / MAC side.
interface udp_tx_packetizer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] tx_data;
    logic       tx_sop;
    logic       tx_eop;
    logic       tx_err;
    logic       tx_wren;
    logic       tx_rdy;

    modport master (
        input  s_data, s_valid, tx_rdy,
        output s_ready, tx_data, tx_sop, tx_eop, tx_err, tx_wren
    );

    modport slave (
        output s_data, s_valid, tx_rdy,
        input  s_ready, tx_data, tx_sop, tx_eop, tx_err, tx_wren
    );
endinterface

// File: rtl/udp_tx_packetizer.sv
// Wraps sample bytes in Ethernet/IPv4/UDP frames (optional 4-byte seq prefix: UDP_PACKETIZER_SEQ_EN).
// 4 cycles IDLE->first byte; tx_rdy low or s_valid low (payload) stalls without losing bytes.
module udp_tx_packetizer #(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [31:0] SRC_IP      = 32'hC0A8_0164,
    parameter logic [31:0] DST_IP      = 32'hC0A8_0101,
    parameter logic [15:0] SRC_PORT    = 16'd5000,
    parameter logic [15:0] DST_PORT    = 16'd5001,
    parameter int          PAYLOAD_LEN = 1024
) (
    input  logic                tx_clk,
    input  logic                rst,
    input  logic                en,
    udp_tx_packetizer_if.master bus,
    output logic                busy,
    output logic [31:0]         seq
);
`ifdef UDP_PACKETIZER_SEQ_EN
    localparam int SEQ_BYTES = 4;
`else
    localparam int SEQ_BYTES = 0;
`endif
    localparam logic [15:0] UDP_LEN  = 16'(8 + SEQ_BYTES + PAYLOAD_LEN);
    localparam logic [15:0] IP_LEN   = 16'(28 + SEQ_BYTES + PAYLOAD_LEN);
    localparam logic [10:0] LAST_PAY = 11'(PAYLOAD_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSUM,
        S_HEADER,
`ifdef UDP_PACKETIZER_SEQ_EN
        S_SEQ,
`endif
        S_PAYLOAD
    } state_t;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [15:0] ethertype;
        logic [7:0]  ver_ihl;
        logic [7:0]  tos;
        logic [15:0] total_len;
        logic [15:0] id;
        logic [15:0] flags_frag;
        logic [7:0]  ttl;
        logic [7:0]  proto;
        logic [15:0] csum;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] udp_len;
        logic [15:0] udp_csum;
    } hdr_t;

    state_t      state_q, state_d;
    logic [10:0] idx_q, idx_d;
    logic [31:0] seq_q, seq_d;
    logic [19:0] sum_q, sum_d;
    logic [15:0] csum_q, csum_d;

    hdr_t        hdr;
    logic [7:0]  hdr_bytes [42];
    logic [19:0] hdr_sum;

    // Only the ID word varies between frames; the rest of the sum folds to constants.
    assign hdr_sum = 20'(16'h4500) + 20'(IP_LEN) + 20'(seq_q[15:0]) + 20'(16'h4000)
                   + 20'(16'h4011) + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
                   + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);

    always_comb begin
        hdr = '{dst_mac: DST_MAC, src_mac: SRC_MAC, ethertype: 16'h0800,
                ver_ihl: 8'h45, tos: 8'h00, total_len: IP_LEN, id: seq_q[15:0],
                flags_frag: 16'h4000, ttl: 8'h40, proto: 8'h11, csum: csum_q,
                src_ip: SRC_IP, dst_ip: DST_IP, src_port: SRC_PORT, dst_port: DST_PORT,
                udp_len: UDP_LEN, udp_csum: 16'h0000};
        for (int i = 0; i < 42; i++) begin
            hdr_bytes[i] = hdr[335 - 8*i -: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        seq_d       = seq_q;
        sum_d       = sum_q;
        csum_d      = csum_q;
        bus.tx_wren = 1'b0;
        bus.tx_sop  = 1'b0;
        bus.tx_eop  = 1'b0;
        bus.tx_data = 8'h00;
        bus.s_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en && bus.s_valid) begin
                    state_d = S_CSUM;
                    idx_d   = '0;
                end
            end
            S_CSUM: begin
                case (idx_q[1:0])
                    2'd0:    sum_d  = hdr_sum;
                    2'd1:    sum_d  = 20'(sum_q[15:0]) + 20'(sum_q[19:16]);
                    default: csum_d = ~(sum_q[15:0] + 16'(sum_q[16]));
                endcase
                idx_d = idx_q + 11'd1;
                if (idx_q[1:0] == 2'd2) begin
                    state_d = S_HEADER;
                    idx_d   = '0;
                end
            end
            S_HEADER: begin
                bus.tx_wren = bus.tx_rdy;
                bus.tx_sop  = (idx_q == 11'd0);
                bus.tx_data = hdr_bytes[idx_q[5:0]];
                if (bus.tx_rdy) begin
                    idx_d = idx_q + 11'd1;
                    if (idx_q == 11'd41) begin
                        idx_d = '0;
`ifdef UDP_PACKETIZER_SEQ_EN
                        state_d = S_SEQ;
`else
                        state_d = S_PAYLOAD;
`endif
                    end
                end
            end
`ifdef UDP_PACKETIZER_SEQ_EN
            S_SEQ: begin
                bus.tx_wren = bus.tx_rdy;
                case (idx_q[1:0])
                    2'd0:    bus.tx_data = seq_q[31:24];
                    2'd1:    bus.tx_data = seq_q[23:16];
                    2'd2:    bus.tx_data = seq_q[15:8];
                    default: bus.tx_data = seq_q[7:0];
                endcase
                if (bus.tx_rdy) begin
                    idx_d = idx_q + 11'd1;
                    if (idx_q == 11'd3) begin
                        idx_d   = '0;
                        state_d = S_PAYLOAD;
                    end
                end
            end
`endif
            S_PAYLOAD: begin
                bus.s_ready = bus.tx_rdy;
                bus.tx_wren = bus.s_valid && bus.tx_rdy;
                bus.tx_data = bus.s_data;
                bus.tx_eop  = (idx_q == LAST_PAY);
                if (bus.s_valid && bus.tx_rdy) begin
                    idx_d = idx_q + 11'd1;
                    if (idx_q == LAST_PAY) begin
                        idx_d   = '0;
                        seq_d   = seq_q + 32'd1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            seq_q   <= '0;
            sum_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            sum_q   <= sum_d;
            csum_q  <= csum_d;
        end
    end

    assign bus.tx_err = 1'b0;
    assign busy       = (state_q != S_IDLE);
    assign seq        = seq_q;
endmodule

// File: doc/udp_tx_packetizer.md
# udp_tx_packetizer

Builds complete Ethernet II / IPv4 / UDP frames around a byte stream of SDR sample data and hands them byte-by-byte to the MAC transmit interface (`tx_data`/`tx_sop`/`tx_eop`/`tx_wren`/`tx_rdy`) in the `tx_clk` domain. Each frame carries a fixed-length payload and, optionally, a 32-bit packet sequence number. The block computes the IPv4 header checksum per packet and leaves the FCS to the MAC.

## Interface
- `DST_MAC`, 48'hFFFF_FFFF_FFFF, destination MAC address.
- `SRC_MAC`, 48'h02_00_00_00_00_01, source MAC address.
- `SRC_IP`, 32'hC0A8_0164, source IPv4 address (192.168.1.100).
- `DST_IP`, 32'hC0A8_0101, destination IPv4 address (192.168.1.1).
- `SRC_PORT`, 16'd5000, UDP source port.
- `DST_PORT`, 16'd5001, UDP destination port.
- `PAYLOAD_LEN`, 1024, sample bytes per frame; legal range 18..1468.
- `tx_clk  in  1`  clock.
- `rst  in  1`  reset: rst, synchronous, active-high; clock tx_clk.
- `en  in  1`  permits new frames to start; a frame in progress always completes.
- `s_data  in  8`  sample byte.
- `s_valid  in  1`  `s_data` is valid.
- `s_ready  out  1`  byte accepted when `s_valid & s_ready`.
- `tx_data  out  8`  byte to the MAC.
- `tx_sop  out  1`  first byte of frame.
- `tx_eop  out  1`  last byte of frame.
- `tx_err  out  1`  tied 0.
- `tx_wren  out  1`  byte transfer strobe.
- `tx_rdy  in  1`  MAC can accept a byte.
- `busy  out  1`  state != IDLE.
- `seq  out  32`  sequence number of the next frame.

## Operation
- A transfer to the MAC occurs on every cycle with `tx_wren` high. `tx_wren` is never high unless `tx_rdy` is high in the same cycle, so it is combinational in `tx_rdy`.
- States:
  - IDLE: `en & s_valid` -> CSUM.
  - CSUM: 3 cycles -> HEADER.
  - HEADER: 42 bytes -> SEQ, or -> PAYLOAD if SEQ is compiled out.
  - SEQ: 4 bytes -> PAYLOAD.
  - PAYLOAD: `PAYLOAD_LEN` bytes -> IDLE. `seq` increments by 1 when the last byte transfers.
- HEADER and SEQ bytes: a byte is presented whenever `tx_rdy` is high (`tx_wren = tx_rdy`). A byte index counter advances on each transfer.
- PAYLOAD: `tx_wren = s_valid & tx_rdy`, `s_ready = tx_rdy` (in PAYLOAD only), `tx_data = s_data`. A stall on either side inserts idle cycles and loses no bytes. `s_ready` is 0 in every other state.
- `tx_sop` is 1 on header byte 0 only. `tx_eop` is 1 on the last payload byte only.
- Header byte order, all fields big-endian:
  - Ethernet: `DST_MAC`, `SRC_MAC`, 0x0800.
  - IPv4: 0x45, 0x00, total_len, ID = `seq[15:0]`, 0x4000 (DF), TTL 0x40, proto 0x11, checksum, `SRC_IP`, `DST_IP`.
  - UDP: `SRC_PORT`, `DST_PORT`, udp_len, 0x0000 (UDP checksum disabled).
- Lengths: S = 4 with SEQ, 0 without. udp_len = 8+S+`PAYLOAD_LEN`; total_len = 20+udp_len. Frame length without FCS is 42+S+`PAYLOAD_LEN`, which is ≥ 60 for every legal `PAYLOAD_LEN`, so no padding is needed.
- Checksum: 20-bit unsigned sum of the ten header 16-bit words with the checksum field as 0 (cycle 1), fold carries into the low 16 bits (cycle 2), fold again and invert (cycle 3).
- SEQ bytes: `seq[31:24]` first. `seq` wraps from 0xFFFFFFFF to 0.
- `en` deasserted mid-frame: the frame completes, then the block stays in IDLE.

## Timing
- Reset values: state IDLE, `seq` = 0, `busy` = 0, `tx_wren`/`tx_sop`/`tx_eop`/`tx_err`/`s_ready` = 0, `tx_data` = 0.
- `rst` mid-frame: next cycle IDLE with all outputs at reset values. The partial frame is abandoned; the MAC discards it because MAC reset clears its FIFO.
- IDLE -> first `tx_wren`: 4 cycles minimum (1 IDLE decision + 3 CSUM), assuming `tx_rdy` is high.
- Back-to-back frames: 1 IDLE cycle + 3 CSUM cycles between the `tx_eop` byte and the next `tx_sop` byte.
- `tx_rdy` low in any state: no transfer, and the byte index holds.

## Configuration
- `UDP_PACKETIZER_SEQ_EN` defined: the SEQ state is included; each payload is prefixed with a 4-byte `seq`; S = 4.
- Not defined: the SEQ state is removed and S = 0. `seq` still counts frames and still drives the IPv4 ID.

## Test plan
- `PAYLOAD_LEN`=18, SEQ on, `tx_rdy`=1, `s_data` = 0x00..0x11 continuous -> 64-byte frame. total_len 0x0032, ID 0x0000, checksum 0xB705, udp_len 0x001E, bytes 42..45 = 00 00 00 00, `tx_eop` on byte 63.
- Same setup with SEQ off -> 60-byte frame, total_len 0x002E, checksum 0xB709, udp_len 0x001A.
- Two back-to-back frames, SEQ on -> second frame has ID 0x0001, SEQ bytes 00 00 00 01, checksum 0xB704; `seq` reads 2 afterward.
- `tx_rdy` toggling 1/0 every cycle plus random `s_valid` gaps -> byte stream identical to the first test, `tx_wren` never high while `tx_rdy` is low, `s_ready` high only in PAYLOAD.
- `rst` pulsed at header byte 20 -> next cycle all outputs 0, `seq` = 0; the next frame starts with `tx_sop` and ID 0x0000.
- `en` dropped at payload byte 5 -> the frame completes with `tx_eop`, `busy` returns to 0, and no new frame starts while `s_valid` = 1.
